// File: rtl/acc16_seq.sv
// rtl/acc16_seq.sv - 16-bit sequential accumulator: sums N_OPS operands, then holds the result until acknowledged.
// Optional build macro ACC16_SATURATE_EN clamps the running sum to 16'hFFFF on any carry-out.

module Add16b (
  input  logic [15:0] i_A,
  input  logic [15:0] i_B,
  input  logic        i_Cin,
  output logic [15:0] o_S,
  output logic        o_Cout
);
  logic [16:0] w_full;

  assign w_full = {1'b0, i_A} + {1'b0, i_B} + {16'd0, i_Cin};
  assign o_S    = w_full[15:0];
  assign o_Cout = w_full[16];
endmodule

module acc16_seq #(
  parameter int N_OPS = 4
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Valid,
  input  logic [15:0] i_Data,
  output logic        o_Ready,
  output logic        o_Valid,
  input  logic        i_Ack,
  output logic [15:0] o_Sum,
  output logic        o_C,
  output logic [3:0]  o_Cnt
);
  typedef enum logic {S_ACC = 1'b0, S_DONE = 1'b1} state_t;

  localparam logic [3:0] LP_N_OPS = 4'(N_OPS);

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_sum;
  logic        r_c;
  logic [3:0]  r_cnt;

  logic [15:0] w_add_s;
  logic        w_add_cout;
  logic [15:0] w_sum_next;
  logic [3:0]  w_cnt_inc;
  logic        w_accept;
  logic        w_clear;

  Add16b u_add (
    .i_A    (r_sum),
    .i_B    (i_Data),
    .i_Cin  (1'b0),
    .o_S    (w_add_s),
    .o_Cout (w_add_cout)
  );

`ifdef ACC16_SATURATE_EN
  assign w_sum_next = w_add_cout ? 16'hFFFF : w_add_s;
`else
  assign w_sum_next = w_add_s;
`endif

  assign w_cnt_inc = r_cnt + 4'd1;
  assign w_accept  = (r_state == S_ACC) && i_Valid;
  assign w_clear   = (r_state == S_DONE) && i_Ack;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state <= S_ACC;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_ACC:  if (i_Valid && (w_cnt_inc == LP_N_OPS)) w_state_next = S_DONE;
      S_DONE: if (i_Ack) w_state_next = S_ACC;
      default: w_state_next = S_ACC;
    endcase
  end

  always_comb begin
    o_Ready = 1'b0;
    o_Valid = 1'b0;
    case (r_state)
      S_ACC:   o_Ready = 1'b1;
      S_DONE:  o_Valid = 1'b1;
      default: o_Ready = 1'b0;
    endcase
  end

  // Datapath registers: load on accept, clear on ack, otherwise hold.
  always_ff @(posedge i_Clk) begin
    if (i_Rst || w_clear) begin
      r_sum <= 16'd0;
      r_c   <= 1'b0;
      r_cnt <= 4'd0;
    end else if (w_accept) begin
      r_sum <= w_sum_next;
      r_c   <= r_c | w_add_cout;
      r_cnt <= w_cnt_inc;
    end
  end

  assign o_Sum = r_sum;
  assign o_C   = r_c;
  assign o_Cnt = r_cnt;
endmodule
